// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, FSM state type and default parameter values for acc_core
package core_pkg;
    localparam int OPCODE_WIDTH_DEF = 5;
    localparam int REG_BIT_CNT_DEF  = 3;
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int PC_WIDTH_DEF     = 8;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_OUT_WAIT, S_HALTED} state_t;
endpackage

// File: rtl/core_alu.sv
// core_alu: combinational accumulator ALU; ports op/acc/operand in, result/carry(borrow for SUB)/zero out
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero
);
    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;
    assign sum  = {1'b0, acc} + {1'b0, operand};
    assign diff = {1'b0, acc} - {1'b0, operand};
    assign result = op == OP_ADD ? sum[DATA_WIDTH-1:0] :
                    op == OP_SUB ? diff[DATA_WIDTH-1:0] :
                    op == OP_AND ? acc & operand :
                    op == OP_OR  ? acc | operand :
                    op == OP_XOR ? acc ^ operand : operand;
    assign carry = op == OP_ADD ? sum[DATA_WIDTH] : op == OP_SUB ? diff[DATA_WIDTH] : 1'b0;
    assign zero  = result == '0;
endmodule

// File: rtl/acc_core.sv
// acc_core: accumulator CPU; clk/rst_ext, run, imem req/addr/valid/data fetch port, out valid/ready/data stream, halted, acc_dbg
module acc_core
    import core_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter int REG_BIT_CNT  = REG_BIT_CNT_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int PC_WIDTH     = PC_WIDTH_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst_ext,
    input  logic                                      run,
    output logic                                      imem_req,
    output logic [PC_WIDTH-1:0]                       imem_addr,
    input  logic                                      imem_valid,
    input  logic [OPCODE_WIDTH+REG_BIT_CNT+DATA_WIDTH-1:0] imem_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic                                      halted,
    output logic [DATA_WIDTH-1:0]                     acc_dbg
);
    localparam int IW = OPCODE_WIDTH + REG_BIT_CNT + DATA_WIDTH;
    state_t state, state_nxt;
    logic [IW-1:0] ir;
    logic [PC_WIDTH-1:0] pc, pc_seq;
    logic [DATA_WIDTH-1:0] acc, operand, imm, alu_result;
    logic [DATA_WIDTH-1:0] regs [2**REG_BIT_CNT];
    logic [OPCODE_WIDTH-1:0] opc;
    logic [3:0] code;
    logic [REG_BIT_CNT-1:0] sel;
    logic z, c, alu_carry, alu_zero, fetch_go, taken, arith;
    assign opc      = ir[IW-1 -: OPCODE_WIDTH];
    assign code     = opc[3:0];
    assign sel      = ir[DATA_WIDTH +: REG_BIT_CNT];
    assign imm      = ir[DATA_WIDTH-1:0];
    assign operand  = opc[4] ? imm : regs[sel];
    assign arith    = code inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    assign taken    = code == OP_JMP || (code == OP_JZ && z) || (code == OP_JC && c);
    assign pc_seq   = pc + 1'b1;
    // Gated by rst_ext so the request is low for the whole reset, not just after the first edge.
    assign imem_req  = state == S_FETCH && run && !rst_ext;
    assign fetch_go  = imem_req && imem_valid;
    assign imem_addr = pc;
    assign acc_dbg   = acc;
    core_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op(code),
        .acc(acc),
        .operand(operand),
        .result(alu_result),
        .carry(alu_carry),
        .zero(alu_zero)
    );
    always_comb begin
        state_nxt = state == S_FETCH    ? (fetch_go ? S_EXEC : S_FETCH) :
                    state == S_EXEC     ? (code == OP_OUT ? S_OUT_WAIT : code == OP_HALT ? S_HALTED : S_FETCH) :
                    state == S_OUT_WAIT ? (out_ready ? S_FETCH : S_OUT_WAIT) : S_HALTED;
    end
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) state <= S_FETCH;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) begin
            ir        <= '0;
            pc        <= '0;
            acc       <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            halted    <= 1'b0;
        end else begin
            if (fetch_go) ir <= imem_data;
            if (state == S_EXEC) begin
                if (code == OP_LD) acc <= operand;
                if (arith) begin
                    acc <= alu_result;
                    c   <= alu_carry;
                    z   <= alu_zero;
                end
                if (code == OP_OUT) begin
                    out_valid <= 1'b1;
                    out_data  <= acc;
                end
                if (code == OP_HALT) halted <= 1'b1;
                // OUT advances the PC only after its handshake; HALT freezes it.
                if (code != OP_OUT && code != OP_HALT) pc <= taken ? imm[PC_WIDTH-1:0] : pc_seq;
            end
            if (state == S_OUT_WAIT && out_ready) begin
                out_valid <= 1'b0;
                pc        <= pc_seq;
            end
        end
    end
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) begin
            for (int i = 0; i < 2**REG_BIT_CNT; i++) regs[i] <= '0;
        end else if (state == S_EXEC && code == OP_ST) begin
            regs[sel] <= acc;
        end
    end
endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 5, instruction opcode field width.
REQ-002 SHALL have parameter REG_BIT_CNT, default 3, register-select width (2^REG_BIT_CNT registers).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, data/immediate width.
REQ-004 SHALL have parameter PC_WIDTH, default 8, instruction address width.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have: rst_ext  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have: run  in  1  fetch enable; low holds core in FETCH without requesting.
REQ-008 SHALL have: imem_req  out  1  fetch request; imem_addr  out  PC_WIDTH  fetch address (=PC).
REQ-009 SHALL have: imem_valid  in  1  fetch data valid; imem_data  in  OPCODE_WIDTH+REG_BIT_CNT+DATA_WIDTH  instruction {opcode, reg, imm}.
REQ-010 SHALL have: out_valid  out  1; out_ready  in  1; out_data  out  DATA_WIDTH  output stream.
REQ-011 SHALL have: halted  out  1  core stopped; acc_dbg  out  DATA_WIDTH  accumulator value.

Function
REQ-012 SHALL implement states FETCH, EXEC, OUT_WAIT, HALTED.
REQ-013 FETCH: imem_req = run; on imem_req & imem_valid latch instruction, go EXEC; imem_valid ignored when imem_req low.
REQ-014 EXEC SHALL take exactly one cycle, then FETCH (except OUT, HALT); minimum 2 cycles/instruction with zero-wait memory.
REQ-015 Opcode low 4 bits: 0 NOP, 1 LD, 2 ST, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JMP, 9 JZ, A JC, B OUT, F HALT; C-E treated as NOP.
REQ-016 Opcode bit 4 SHALL select operand: 1 = imm, 0 = reg[sel]; applies to LD/ADD/SUB/AND/OR/XOR only.
REQ-017 LD: acc <= operand; ST: reg[sel] <= acc; flags unchanged by LD/ST.
REQ-018 ADD/SUB: DATA_WIDTH+1-bit result; acc <= low bits; C <= carry (ADD) or borrow (SUB); Z <= (result low bits == 0).
REQ-019 AND/OR/XOR: acc <= result; Z updated; C <= 0.
REQ-020 JMP: PC <= imm[PC_WIDTH-1:0]; JZ/JC: same when Z/C is 1, else PC+1.
REQ-021 All other instructions: PC <= PC+1 modulo 2^PC_WIDTH (wrap max -> 0).
REQ-022 OUT: out_data <= acc, out_valid <= 1, go OUT_WAIT; on out_valid & out_ready drop out_valid, PC+1, go FETCH; out_data stable while waiting.
REQ-023 HALT: halted <= 1, enter HALTED; HALTED exits only by reset; imem_req 0 there.
REQ-024 run deassertion SHALL only affect FETCH; an in-flight EXEC/OUT_WAIT completes.
REQ-025 acc_dbg SHALL equal acc register continuously.

Reset
REQ-026 While rst_ext high: state FETCH, PC 0, acc 0, all registers 0, Z/C 0, imem_req 0, out_valid 0, out_data 0, halted 0.
REQ-027 Reset mid-fetch or mid-OUT_WAIT SHALL abort the transaction; first request after release at address 0.

Structure
REQ-028 Shared package core_pkg SHALL hold opcode constants, state enum, default parameter values.
REQ-029 Datapath arithmetic SHALL sit in one sub-module core_alu (combinational: operation, acc, operand -> result, carry, zero).
REQ-030 Register file SHALL be internal flops, one write port, one combinational read port.

Verification
REQ-031 Program LDI 5; ADDI 3; ST r2; OUT; HALT -> out_data 8, reg2 8, halted 1, PC stops at 4.
REQ-032 LDI 0xFFFF; ADDI 1 -> acc 0, Z 1, C 1; then JC 0x10 -> next imem_addr 0x10.
REQ-033 LDI 3; SUBI 4 -> acc 0xFFFF, C 1, Z 0; JZ 7 not taken -> next address PC+1.
REQ-034 OUT with out_ready low 5 cycles -> out_valid held, out_data stable, no fetch until handshake.
REQ-035 imem_valid delayed 3 cycles plus run toggled low in FETCH -> no instruction loss or duplication.
REQ-036 PC at 0xFF executing NOP -> next fetch address 0x00; rst_ext pulse during OUT_WAIT -> out_valid 0, fetch restarts at 0.
